// File: rtl/phase_sequencer_if.sv
// Phase sequencer bundle: control inputs, phase strobes, status and counters.
// master = sequencer side, slave = control/datapath side.
interface phase_sequencer_if #(
    parameter int NPHASE = 5,
    parameter int CNT_W  = 32
);
    localparam int IW = $clog2(NPHASE);

    logic              exec;
    logic              mode_step;
    logic              halt_req;
    logic              mem_busy;
    logic              bp_en;
    logic [15:0]       bp_addr;
    logic [15:0]       pc;
    logic [NPHASE-1:0] phase;
    logic [IW-1:0]     phase_idx;
    logic              running;
    logic              halted;
    logic              bp_hit;
    logic              instr_done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        input  exec, mode_step, halt_req, mem_busy,
        input  bp_en, bp_addr, pc,
        output phase, phase_idx, running, halted,
        output bp_hit, instr_done, cycle_cnt, instr_cnt
    );

    modport slave (
        output exec, mode_step, halt_req, mem_busy,
        output bp_en, bp_addr, pc,
        input  phase, phase_idx, running, halted,
        input  bp_hit, instr_done, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multicycle one-hot phase sequencer: run/step/halt, mem stall, PC breakpoint.
// Define PERF_CNT_EN to build the cycle/instruction counters (else tied to 0).
module phase_sequencer #(
    parameter int NPHASE    = 5,
    parameter int MEM_PHASE = 3,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    phase_sequencer_if.master  bus
);
    localparam int IW = $clog2(NPHASE);
    localparam logic [IW-1:0] LAST = IW'(NPHASE - 1);
    localparam logic [IW-1:0] MEMP = IW'(MEM_PHASE);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NPHASE-1:0] phase_q, phase_d;
    logic              bp_q, bp_d;
    logic              exempt_q, exempt_d;
    logic              done_q, done_d;
    logic              stall;

    assign stall = (idx_q == MEMP) && bus.mem_busy;

    // pc is expected to carry its post-update value at the last-phase edge
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bp_d     = bp_q;
        exempt_d = exempt_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.exec) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    bp_d     = 1'b0;
                    exempt_d = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (idx_q == LAST) begin
                        done_d   = 1'b1;
                        exempt_d = 1'b0;
                        idx_d    = '0;
                        if (bus.halt_req) begin
                            state_d = HALT;
                        end else if (bus.mode_step) begin
                            state_d = IDLE;
                        end else if (bus.bp_en && !exempt_q &&
                                     bus.pc == bus.bp_addr) begin
                            state_d = IDLE;
                            bp_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        phase_d = (state_d == RUN) ? (NPHASE'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= '0;
            bp_q     <= 1'b0;
            exempt_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            bp_q     <= bp_d;
            exempt_q <= exempt_d;
            done_q   <= done_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.phase_idx  = idx_q;
    assign bus.running    = (state_q == RUN);
    assign bus.halted     = (state_q == HALT);
    assign bus.bp_hit     = bp_q;
    assign bus.instr_done = done_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q == RUN) cyc_q <= cyc_q + CNT_W'(1);
            if (done_d)         ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.instr_cnt = ins_q;
`else
    assign bus.cycle_cnt = {CNT_W{1'b0}};
    assign bus.instr_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: per-instruction expectations from a
// behavioural model, checked by a negedge monitor.
module tb_phase_sequencer;
    localparam int NP  = 5;
    localparam int MEM = 3;
    localparam int CW  = 4;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int len;
        int s;
        int st;
        bit bp;
        int icnt;
        int ccnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   pos;
    int   icnt;
    int   ccnt;
    bit   bp_state;
    logic [15:0] bp_val;
    exp_t exp_q[$];

    phase_sequencer_if #(.NPHASE(NP), .CNT_W(CW)) bus ();

    phase_sequencer #(
        .NPHASE(NP), .MEM_PHASE(MEM), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name,
                                input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int exp_idx(input int s, input int p);
        if (p <= MEM) return p;
        if (p <= MEM + s) return MEM;
        return p - s;
    endfunction

    function automatic int cmask(input int v);
        return PERF ? (v % (1 << CW)) : 0;
    endfunction

    // Monitor: pops one expectation per instr_done, walks the phase trace
    always @(negedge clk) begin : mon
        exp_t e;
        int ei;
        logic [NP-1:0] oh;
        if (rst_n) begin
            if (bus.instr_done) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(pos == e.len, "instr_len", pos, e.len);
                    chk(bus.running == (e.st == 0), "running",
                        bus.running, e.st == 0);
                    chk(bus.halted == (e.st == 2), "halted",
                        bus.halted, e.st == 2);
                    chk(bus.bp_hit == e.bp, "bp_hit", bus.bp_hit, e.bp);
                    chk(int'(bus.instr_cnt) == e.icnt, "instr_cnt",
                        bus.instr_cnt, e.icnt);
                    chk(int'(bus.cycle_cnt) == e.ccnt, "cycle_cnt",
                        bus.cycle_cnt, e.ccnt);
                end
                pos = 0;
            end
            if (exp_q.size() == 0) begin
                chk(bus.phase == '0, "idle_phase", bus.phase, 0);
                chk(bus.phase_idx == '0, "idle_idx", bus.phase_idx, 0);
            end else begin
                ei = exp_idx(exp_q[0].s, pos);
                oh = '0;
                oh[ei] = 1'b1;
                chk(bus.phase == oh, "phase", bus.phase, oh);
                chk(int'(bus.phase_idx) == ei, "phase_idx",
                    bus.phase_idx, ei);
                pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.mem_busy  = 1'($urandom);
        bus.halt_req  = 1'($urandom);
        bus.mode_step = 1'($urandom);
        bus.bp_en     = 1'($urandom);
        bus.bp_addr   = 16'($urandom);
        bus.pc        = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            bus.exec = 1'b0;
            tick();
        end
    endtask

    task automatic start();
        noise();
        bus.exec = 1'b1;
        bp_state = 1'b0;
        tick();
        bus.exec = 1'b0;
    endtask

    // One instruction: s stall clocks; h/st/be/pcv apply at the last phase
    task automatic instr(input int s, input bit h, input bit st,
                         input bit be, input logic [15:0] pcv,
                         input bit first, output int outcome);
        exp_t e;
        int len;
        len = NP + s;
        if (h) outcome = 2;
        else if (st) outcome = 1;
        else if (be && pcv == bp_val && !first) outcome = 3;
        else outcome = 0;
        if (outcome == 3) bp_state = 1'b1;
        icnt++;
        ccnt += len;
        e.len  = len;
        e.s    = s;
        e.st   = (outcome == 3) ? 1 : outcome;
        e.bp   = bp_state;
        e.icnt = cmask(icnt);
        e.ccnt = cmask(ccnt);
        exp_q.push_back(e);
        for (int c = 0; c < len; c++) begin
            noise();
            if (c >= MEM && c <= MEM + s) bus.mem_busy = (c < MEM + s);
            bus.exec = ($urandom % 6 == 0);
            if (c == len - 1) begin
                bus.halt_req  = h;
                bus.mode_step = st;
                bus.bp_en     = be;
                bus.bp_addr   = bp_val;
                bus.pc        = pcv;
            end
            tick();
        end
        bus.exec = 1'b0;
        bus.mem_busy = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        chk(bus.phase == '0, {tag, "_phase"}, bus.phase, 0);
        chk(bus.phase_idx == '0, {tag, "_idx"}, bus.phase_idx, 0);
        chk(!bus.running, {tag, "_running"}, bus.running, 0);
        chk(!bus.halted, {tag, "_halted"}, bus.halted, 0);
        chk(!bus.bp_hit, {tag, "_bp_hit"}, bus.bp_hit, 0);
        chk(!bus.instr_done, {tag, "_done"}, bus.instr_done, 0);
        chk(bus.cycle_cnt == '0, {tag, "_cycle_cnt"}, bus.cycle_cnt, 0);
        chk(bus.instr_cnt == '0, {tag, "_instr_cnt"}, bus.instr_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        reset_chk(tag);
        exp_q.delete();
        pos = 0;
        icnt = 0;
        ccnt = 0;
        bp_state = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        reset_chk({tag, "_rel"});
    endtask

    initial begin : drv
        int out;
        bit first;
        exp_t d;
        errors = 0;
        checks = 0;
        pos = 0;
        icnt = 0;
        ccnt = 0;
        bp_state = 1'b0;
        bp_val = 16'h0;
        rst_n = 1'b0;
        bus.exec = 1'b0;
        noise();
        tick();
        do_reset("reset");

        // continuous run, 4 back-to-back instructions, stop by step
        start();
        for (int i = 0; i < 4; i++)
            instr(0, 0, i == 3, 0, 16'(i + 1), i == 0, out);
        idle(3);

        // single-step: three exec pulses, one instruction each
        for (int k = 0; k < 3; k++) begin
            start();
            instr(0, 0, 1, 0, 16'(k), 1, out);
            idle(9);
        end

        // four-clock memory stall
        start();
        instr(4, 0, 1, 0, 16'h0, 1, out);
        idle(2);

        // breakpoint at 0x0004, then resume past it
        bp_val = 16'h0004;
        start();
        for (int p = 1; p <= 4; p++)
            instr(0, 0, 0, 1, 16'(p), p == 1, out);
        chk(bus.bp_hit == 1'b1, "bp_stop", bus.bp_hit, 1);
        idle(3);
        start();
        chk(bus.bp_hit == 1'b0, "bp_clear", bus.bp_hit, 0);
        instr(0, 0, 0, 1, 16'h0005, 1, out);
        instr(0, 0, 1, 1, 16'h0006, 0, out);
        idle(2);

        // resume exactly at the breakpoint address is exempt once
        bp_val = 16'h0006;
        start();
        instr(0, 0, 0, 1, 16'h0006, 1, out);
        instr(0, 0, 0, 1, 16'h0006, 0, out);
        idle(2);

        // randomized mix of stalls, steps and breakpoints
        start();
        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bp_val = 16'($urandom % 8);
            instr($urandom % 4, 0, ($urandom % 5 == 0), 1'($urandom),
                  16'($urandom % 8), first, out);
            first = 1'b0;
            if (out != 0) begin
                idle(1 + $urandom % 4);
                start();
                first = 1'b1;
            end
        end
        instr(0, 0, 1, 0, 16'h0, first, out);
        idle(2);

        // halt has priority over step; exec is ignored afterwards
        start();
        instr(0, 1, 1, 0, 16'h0, 1, out);
        for (int k = 0; k < 3; k++) begin
            bus.exec = 1'b1;
            tick();
            bus.exec = 1'b0;
            idle(4);
        end
        chk(bus.halted == 1'b1, "halt_hold", bus.halted, 1);
        chk(bus.running == 1'b0, "halt_norun", bus.running, 0);
        do_reset("halt_exit");

        // asynchronous reset during phase[2]
        start();
        d.len = NP; d.s = 0; d.st = 0; d.bp = 0; d.icnt = 0; d.ccnt = 0;
        exp_q.push_back(d);
        tick();
        tick();
        chk(bus.phase == NP'(4), "pre_reset_p2", bus.phase, 4);
        do_reset("mid_reset");

        // counter wrap: 17 instructions after reset
        start();
        for (int i = 0; i < 17; i++)
            instr(0, 0, i == 16, 0, 16'h0, i == 0, out);
        chk(int'(bus.instr_cnt) == (PERF ? 1 : 0), "wrap_instr_cnt",
            bus.instr_cnt, PERF ? 1 : 0);
        idle(3);
        chk(exp_q.size() == 0, "pending_expect", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
